// File: rtl/font_rom_arbiter_pkg.sv
// Shared constants for the text-overlay font ROM arbiter: colours, overlay slots
// and the font ROM address width.
package font_rom_arbiter_pkg;

  localparam int FONT_ADDR_W = 11;

  localparam logic [2:0] BLACK     = 3'b000;
  localparam logic [2:0] BLUE      = 3'b001;
  localparam logic [2:0] GREEN     = 3'b010;
  localparam logic [2:0] LIGHTBLUE = 3'b011;
  localparam logic [2:0] RED       = 3'b100;
  localparam logic [2:0] PINK      = 3'b101;
  localparam logic [2:0] YELLOW    = 3'b110;
  localparam logic [2:0] WHITE     = 3'b111;

  // Requester slots in priority order; lower index wins.
  localparam int OVL_START = 0;
  localparam int OVL_TURN  = 1;
  localparam int OVL_SCORE = 2;
  localparam int OVL_END   = 3;

endpackage

// File: rtl/font_rom_arbiter_prio.sv
// Fixed-priority encoder: lowest set index wins, plus any/multi flags.
module font_req_prio #(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] live_i,
  output logic [IDW-1:0]  winner_o,
  output logic            any_o,
  output logic            multi_o
);

  always_comb begin
    winner_o = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (live_i[i]) winner_o = IDW'(i);
    end
    any_o   = |live_i;
    // Clearing the lowest set bit leaves something only if two or more were set.
    multi_o = |(live_i & (live_i - NREQ'(1)));
  end

endmodule

// File: rtl/font_rom_arbiter.sv
// Two-stage font ROM arbiter: stage A picks a requester and addresses the ROM,
// stage B turns the returned font row into the registered pixel.
module font_rom_arbiter
  import font_rom_arbiter_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int ADDR_W = FONT_ADDR_W,
  parameter int DATA_W = 8,
  parameter int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pixel_tick,
  input  logic [NREQ-1:0]        req_on,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*3-1:0]      req_bit,
  input  logic [NREQ*3-1:0]      req_color,
  input  logic                   mask_we,
  input  logic [NREQ-1:0]        mask_in,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [DATA_W-1:0]      rom_data,
  output logic                   text_on,
  output logic [2:0]             text_rgb,
  output logic [IDW-1:0]         grant_id,
  output logic [7:0]             conflict_cnt
);

  logic [NREQ-1:0]   mask_q, mask_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [2:0]        bit_q, bit_d;
  logic [2:0]        color_q, color_d;
  logic              on_q, on_d;
  logic [IDW-1:0]    id_q, id_d;
  logic              valid_a_q, valid_a_d;
  logic              text_on_q, text_on_d;
  logic [2:0]        text_rgb_q, text_rgb_d;
  logic [IDW-1:0]    grant_id_q, grant_id_d;
  logic [7:0]        cnt_q, cnt_d;

  logic [NREQ-1:0] live;
  logic [IDW-1:0]  winner;
  logic            any_live;
  logic            multi_live;

  assign live = req_on & mask_q;

  font_req_prio #(.NREQ(NREQ), .IDW(IDW)) u_prio (
    .live_i   (live),
    .winner_o (winner),
    .any_o    (any_live),
    .multi_o  (multi_live)
  );

  always_comb begin
    mask_d     = mask_q;
    rom_addr_d = rom_addr_q;
    bit_d      = bit_q;
    color_d    = color_q;
    on_d       = on_q;
    id_d       = id_q;
    text_on_d  = text_on_q;
    text_rgb_d = text_rgb_q;
    grant_id_d = grant_id_q;
    cnt_d      = cnt_q;
    valid_a_d  = pixel_tick;

    if (pixel_tick) begin
      on_d = any_live;
      id_d = any_live ? winner : '0;
      // With nothing live the ROM address is left alone to avoid needless toggling.
      if (any_live) begin
        rom_addr_d = req_addr[int'(winner)*ADDR_W +: ADDR_W];
        bit_d      = req_bit[int'(winner)*3 +: 3];
        color_d    = req_color[int'(winner)*3 +: 3];
      end
      if (multi_live && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end

    // Stage B uses the stage A registers as they stood before this edge, so a
    // back-to-back tick still retires the older pixel here.
    if (valid_a_q) begin
      text_on_d  = on_q;
      grant_id_d = id_q;
      text_rgb_d = (on_q && rom_data[~bit_q]) ? color_q : BLACK;
    end

    if (mask_we) mask_d = mask_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q     <= '1;
      rom_addr_q <= '0;
      bit_q      <= '0;
      color_q    <= '0;
      on_q       <= 1'b0;
      id_q       <= '0;
      valid_a_q  <= 1'b0;
      text_on_q  <= 1'b0;
      text_rgb_q <= '0;
      grant_id_q <= '0;
      cnt_q      <= '0;
    end else begin
      mask_q     <= mask_d;
      rom_addr_q <= rom_addr_d;
      bit_q      <= bit_d;
      color_q    <= color_d;
      on_q       <= on_d;
      id_q       <= id_d;
      valid_a_q  <= valid_a_d;
      text_on_q  <= text_on_d;
      text_rgb_q <= text_rgb_d;
      grant_id_q <= grant_id_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rom_addr     = rom_addr_q;
  assign text_on      = text_on_q;
  assign text_rgb     = text_rgb_q;
  assign grant_id     = grant_id_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Self-checking bench for font_rom_arbiter: directed scenarios plus random
// pixels checked against a pixel-level reference model and a bench-owned font ROM.
module tb_font_rom_arbiter;
  import font_rom_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        pixelTick;
  logic [3:0]  reqOn;
  logic [43:0] reqAddr;
  logic [11:0] reqBit;
  logic [11:0] reqColor;
  logic        maskWe;
  logic [3:0]  maskIn;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic        text_on;
  logic [2:0]  text_rgb;
  logic [1:0]  grant_id;
  logic [7:0]  conflict_cnt;

  logic [7:0] romMem [0:2047];

  int checks = 0;
  int errors = 0;

  // Reference state: mask, conflict count, last driven ROM address, last outputs.
  logic [3:0]  maskM;
  int          cntM;
  logic [10:0] prevAddrM;
  logic        lastOn;
  logic [2:0]  lastRgb;
  logic [1:0]  lastId;

  font_rom_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .pixel_tick   (pixelTick),
    .req_on       (reqOn),
    .req_addr     (reqAddr),
    .req_bit      (reqBit),
    .req_color    (reqColor),
    .mask_we      (maskWe),
    .mask_in      (maskIn),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .text_on      (text_on),
    .text_rgb     (text_rgb),
    .grant_id     (grant_id),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  // The ROM word follows the registered address within the cycle it is presented.
  assign rom_data = romMem[rom_addr];

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] on, input int slot, input logic [10:0] addr,
                               input logic [2:0] bitIdx, input logic [2:0] color);
    reqOn = on;
    reqAddr[slot*11 +: 11] = addr;
    reqBit[slot*3 +: 3]    = bitIdx;
    reqColor[slot*3 +: 3]  = color;
  endtask

  task automatic randomStimulus();
    reqOn = 4'($urandom_range(0, 15));
    for (int i = 0; i < 4; i++) begin
      reqAddr[i*11 +: 11] = 11'($urandom_range(0, 2047));
      reqBit[i*3 +: 3]    = 3'($urandom_range(0, 7));
      reqColor[i*3 +: 3]  = 3'($urandom_range(0, 7));
    end
  endtask

  // Predicts what one ticked pixel should produce from the current inputs.
  task automatic modelPixel(output logic eOn, output logic [10:0] eAddr,
                            output logic [1:0] eId, output logic [2:0] eRgb);
    logic [3:0] live;
    logic [7:0] row;
    int         sel;
    live  = reqOn & maskM;
    sel   = -1;
    for (int i = 0; i < 4; i++) begin
      if (live[i]) begin
        sel = i;
        break;
      end
    end
    eOn   = (sel >= 0);
    eAddr = prevAddrM;
    eId   = 2'd0;
    eRgb  = BLACK;
    if (sel >= 0) begin
      eAddr = reqAddr[sel*11 +: 11];
      eId   = 2'(sel);
      row   = romMem[eAddr];
      if (row[3'd7 - reqBit[sel*3 +: 3]]) eRgb = reqColor[sel*3 +: 3];
    end
    if ($countones(live) >= 2 && cntM < 255) cntM++;
    prevAddrM = eAddr;
    if (maskWe) maskM = maskIn;
  endtask

  // One ticked pixel followed by one idle clock; called and returns at a negedge.
  task automatic doTick();
    logic eOn;
    logic [10:0] eAddr;
    logic [1:0] eId;
    logic [2:0] eRgb;
    modelPixel(eOn, eAddr, eId, eRgb);
    pixelTick = 1'b1;
    @(negedge clk);
    checkOutput("rom_addr", 32'(rom_addr), 32'(eAddr));
    checkOutput("conflict_cnt", 32'(conflict_cnt), 32'(cntM));
    checkOutput("hold_text_on", 32'(text_on), 32'(lastOn));
    checkOutput("hold_text_rgb", 32'(text_rgb), 32'(lastRgb));
    pixelTick = 1'b0;
    maskWe    = 1'b0;
    @(negedge clk);
    checkOutput("text_on", 32'(text_on), 32'(eOn));
    checkOutput("text_rgb", 32'(text_rgb), 32'(eRgb));
    checkOutput("grant_id", 32'(grant_id), 32'(eId));
    lastOn  = eOn;
    lastRgb = eRgb;
    lastId  = eId;
  endtask

  task automatic resetModel();
    maskM     = 4'hF;
    cntM      = 0;
    prevAddrM = '0;
    lastOn    = 1'b0;
    lastRgb   = BLACK;
    lastId    = 2'd0;
  endtask

  initial begin
    logic e1On, e2On;
    logic [10:0] e1Addr, e2Addr;
    logic [1:0] e1Id, e2Id;
    logic [2:0] e1Rgb, e2Rgb;

    for (int a = 0; a < 2048; a++) romMem[a] = 8'($urandom_range(0, 255));
    romMem[11'h530] = 8'b1000_0000;
    romMem[11'h222] = 8'h00;

    reset = 1'b1; pixelTick = 1'b0; reqOn = '0; reqAddr = '0; reqBit = '0;
    reqColor = '0; maskWe = 1'b0; maskIn = '0;
    resetModel();
    repeat (3) @(negedge clk);
    checkOutput("reset_text_on", 32'(text_on), 32'd0);
    checkOutput("reset_text_rgb", 32'(text_rgb), 32'd0);
    checkOutput("reset_rom_addr", 32'(rom_addr), 32'd0);
    checkOutput("reset_grant_id", 32'(grant_id), 32'd0);
    checkOutput("reset_cnt", 32'(conflict_cnt), 32'd0);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    // Single requester on slot 2 with the leftmost font pixel lit.
    applyStimulus(4'b0100, 2, 11'h530, 3'd0, GREEN);
    doTick();
    checkOutput("single_rom_addr", 32'(rom_addr), 32'h530);
    checkOutput("single_rgb", 32'(text_rgb), 32'(GREEN));
    checkOutput("single_grant", 32'(grant_id), 32'd2);

    // Priority among three live requesters, first conflict.
    applyStimulus(4'b1011, 0, 11'h123, 3'd5, RED);
    doTick();
    checkOutput("prio_grant", 32'(grant_id), 32'd0);
    checkOutput("prio_cnt", 32'(conflict_cnt), 32'd1);

    // Font bit off still reports coverage but black colour.
    applyStimulus(4'b0001, 0, 11'h222, 3'd3, WHITE);
    doTick();
    checkOutput("fontoff_on", 32'(text_on), 32'd1);
    checkOutput("fontoff_rgb", 32'(text_rgb), 32'd0);

    // Mask written on a tick applies only from the following tick.
    applyStimulus(4'b0001, 0, 11'h530, 3'd0, YELLOW);
    maskWe = 1'b1; maskIn = 4'b1110;
    doTick();
    checkOutput("mask_old_on", 32'(text_on), 32'd1);
    doTick();
    checkOutput("mask_new_on", 32'(text_on), 32'd0);
    checkOutput("mask_new_rgb", 32'(text_rgb), 32'd0);

    maskWe = 1'b1; maskIn = 4'hF;
    @(negedge clk);
    maskWe = 1'b0; maskM = 4'hF;
    @(negedge clk);

    // Back-to-back ticks: both pixels come out, in order, one clock apart.
    randomStimulus(); reqOn[0] = 1'b1;
    modelPixel(e1On, e1Addr, e1Id, e1Rgb);
    pixelTick = 1'b1;
    @(negedge clk);
    checkOutput("b2b_addr1", 32'(rom_addr), 32'(e1Addr));
    randomStimulus(); reqOn[3] = 1'b1;
    modelPixel(e2On, e2Addr, e2Id, e2Rgb);
    @(negedge clk);
    pixelTick = 1'b0;
    checkOutput("b2b_on1", 32'(text_on), 32'(e1On));
    checkOutput("b2b_rgb1", 32'(text_rgb), 32'(e1Rgb));
    checkOutput("b2b_id1", 32'(grant_id), 32'(e1Id));
    checkOutput("b2b_addr2", 32'(rom_addr), 32'(e2Addr));
    @(negedge clk);
    checkOutput("b2b_on2", 32'(text_on), 32'(e2On));
    checkOutput("b2b_rgb2", 32'(text_rgb), 32'(e2Rgb));
    checkOutput("b2b_id2", 32'(grant_id), 32'(e2Id));
    lastOn = e2On; lastRgb = e2Rgb; lastId = e2Id;
    @(negedge clk);

    // Random pixels with occasional mask writes and idle gaps.
    for (int n = 0; n < 60; n++) begin
      randomStimulus();
      maskWe = ($urandom_range(0, 4) == 0);
      maskIn = 4'($urandom_range(0, 15));
      doTick();
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        checkOutput("idle_hold_on", 32'(text_on), 32'(lastOn));
        checkOutput("idle_hold_rgb", 32'(text_rgb), 32'(lastRgb));
        checkOutput("idle_hold_id", 32'(grant_id), 32'(lastId));
      end
    end

    maskWe = 1'b1; maskIn = 4'hF;
    @(negedge clk);
    maskWe = 1'b0; maskM = 4'hF;

    // Conflict counter saturation.
    for (int n = 0; n < 300; n++) begin
      randomStimulus();
      reqOn = 4'b0011;
      doTick();
    end
    checkOutput("cnt_saturated", 32'(conflict_cnt), 32'd255);

    // Reset one clock after a tick discards the in-flight pixel.
    applyStimulus(4'b0001, 0, 11'h530, 3'd0, WHITE);
    pixelTick = 1'b1;
    @(negedge clk);
    pixelTick = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_on", 32'(text_on), 32'd0);
    checkOutput("midrst_rgb", 32'(text_rgb), 32'd0);
    checkOutput("midrst_addr", 32'(rom_addr), 32'd0);
    checkOutput("midrst_cnt", 32'(conflict_cnt), 32'd0);
    reset = 1'b0;
    resetModel();
    repeat (3) begin
      @(negedge clk);
      checkOutput("post_rst_on", 32'(text_on), 32'd0);
      checkOutput("post_rst_rgb", 32'(text_rgb), 32'd0);
    end

    applyStimulus(4'b1000, 3, 11'h530, 3'd0, PINK);
    doTick();
    checkOutput("post_rst_pixel", 32'(text_rgb), 32'(PINK));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/font_rom_arbiter.md
Name: font_rom_arbiter

Overview:
- Shares the single synchronous font ROM (1-clock read latency) between up to NREQ text-overlay generators: start screen, turn banner, score line and game-over text.
- Each pixel_tick it grants the highest-priority enabled requester and drives the ROM address.
- It then realigns the returned font row with the granted requester's bit index and colour, and emits the final registered text_on/text_rgb to the VGA mux.
- A config mask, driven by the game state machine, selects which overlays are live.

Parameters:
- NREQ, 4, number of requesters; index 0 is highest priority.
- ADDR_W, 11, font ROM address width ({char[6:0], row[3:0]}).
- DATA_W, 8, font ROM word width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pixel_tick  in  1  pixel strobe; consecutive ticks are at least 2 clk apart
- req_on  in  NREQ  requester i is over its text region this pixel
- req_addr  in  NREQ*ADDR_W  packed ROM address per requester
- req_bit  in  NREQ*3  packed bit index (pix_x[4:2]-style) per requester
- req_color  in  NREQ*3  packed 3-bit RGB foreground per requester
- mask_we  in  1  load enable for the overlay mask
- mask_in  in  NREQ  new overlay enable mask
- rom_addr  out  ADDR_W  registered address to the font ROM
- rom_data  in  DATA_W  ROM word, valid 1 clk after rom_addr changes
- text_on  out  1  registered: a live overlay covers this pixel
- text_rgb  out  3  registered pixel colour (black 3'b000 when font bit is 0)
- grant_id  out  clog2(NREQ)  registered index of the requester that produced text_on
- conflict_cnt  out  8  saturating count of ticks with more than one live requester

Behaviour:
- Reset values:
  - rom_addr=0, text_on=0, text_rgb=0, grant_id=0, conflict_cnt=0.
  - mask = all ones; internal stage valids = 0.
- Live vector: live = req_on & mask.
- Stage A, on the clk where pixel_tick=1:
  - winner = lowest index set in live.
  - Register rom_addr=req_addr[winner], bit_q=req_bit[winner], color_q=req_color[winner], on_q=|live, id_q=winner, and set valid_a=1.
  - If live=0: on_q=0; rom_addr holds its previous value; id_q=0.
- Stage B, on the clk after stage A (valid_a=1):
  - font_bit = rom_data[~bit_q] (MSB is the leftmost pixel).
  - Register text_on=on_q, grant_id=id_q.
  - text_rgb = color_q if on_q and font_bit, else 3'b000.
  - Clear valid_a.
- Latency: outputs update exactly 2 clk after the pixel_tick clk, then hold until the next update.
- Outputs never change on clks that are not stage-B clks.
- Mask:
  - mask_we loads mask_in at the clock edge.
  - On a clk where mask_we and pixel_tick coincide, stage A uses the old mask; the new mask applies from the next tick.
- conflict_cnt:
  - Increments on each tick where popcount(live) >= 2.
  - Saturates at 255; cleared only by reset.
- Reset asserted mid-pipeline: the in-flight pixel is discarded, and all outputs read reset values on the clk after reset.
- Violating the tick-spacing constraint: if pixel_tick arrives while valid_a=1, stage A captures the new pixel, stage B still completes the old one that same clk, and no output is dropped or duplicated.
- No combinational path from inputs to outputs; rom_addr is the only ROM-facing output.

Decomposition:
- Shared package holds:
  - colour localparams (BLACK, RED, GREEN, BLUE, WHITE, PINK, YELLOW, LIGHTBLUE)
  - overlay index constants (OVL_START=0, OVL_TURN=1, OVL_SCORE=2, OVL_END=3)
  - FONT_ADDR_W=11
- One sub-module: font_req_prio, a combinational NREQ-bit fixed-priority encoder producing winner index, any, and multi flags.

Test Plan:
- Single requester: reset, mask=4'b1111, req_on=4'b0100, req_addr[2]=11'h530, ROM row 8'b1000_0000, req_bit[2]=0, color GREEN, tick at clk 10 -> rom_addr=11'h530 at clk 11; text_on=1, text_rgb=3'b010, grant_id=2 at clk 12.
- Priority: req_on=4'b1011, tick -> grant_id=0, rom_addr=req_addr[0]; conflict_cnt increments from 0 to 1.
- Mask: mask_we=1, mask_in=4'b1110 on the same clk as a tick with req_on=4'b0001 -> that pixel shows text_on=1; next tick with the same req_on -> text_on=0, text_rgb=0.
- Font bit off: ROM row 8'h00, req_on=4'b0001 -> text_on=1, text_rgb=3'b000.
- Saturation: 300 ticks with req_on=4'b0011 -> conflict_cnt=255.
- Reset mid-flight: tick, then reset on the next clk -> text_on=0, text_rgb=0, rom_addr=0, and no stale pixel appears after reset deasserts.
